// File: rtl/vga_ctrl.sv
// vga_ctrl: raster timing generator with pixel-enable divider.
// Drives frame-buffer address, re-times rgb with sync/blank.
//
// Ports:
//   Clk         system clock, rising edge
//   Rst         async active-low reset
//   Enable      1 = run raster, 0 = hold counters, blank outputs
//   vga_data    {R,G,B} returned for h_addr/v_addr (combinational)
//   h_addr      visible column, 0 outside active area
//   v_addr      visible row, 0 outside active area
//   hsync       horizontal sync, active-low
//   vsync       vertical sync, active-low
//   valid       vga_r/g/b carries a visible pixel
//   vga_r/g/b   pixel colour, 0 when blanked
//   frame_start one-Clk pulse when raster wraps to (0,0)
`timescale 1ns/1ps

module vga_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Enable,
  input  logic [23:0] vga_data,
  output logic [9:0]  h_addr,
  output logic [8:0]  v_addr,
  output logic        hsync,
  output logic        vsync,
  output logic        valid,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  localparam int H_TOTAL =
    H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL =
    V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;

  // +1 so the exclusive end bound always fits
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int DW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST =
    DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST  =
    HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  =
    VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_SYN_C = HW'(H_SYNC);
  localparam logic [VW-1:0] V_SYN_C = VW'(V_SYNC);
  localparam logic [HW-1:0] H_BEG_C = HW'(H_START);
  localparam logic [VW-1:0] V_BEG_C = VW'(V_START);
  localparam logic [HW-1:0] H_END_C =
    HW'(H_START + H_ACTIVE);
  localparam logic [VW-1:0] V_END_C =
    VW'(V_START + V_ACTIVE);

  logic [DW-1:0] r_div;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_valid;
  logic          r_fs;
  logic [23:0]   r_rgb;

  logic          w_pix_en;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_h_act;
  logic          w_v_act;
  logic          w_active;
  logic [HW-1:0] w_h_off;
  logic [VW-1:0] w_v_off;

  assign w_pix_en = Enable && (r_div == DIV_LAST);
  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);

  assign w_h_act = (r_h_cnt >= H_BEG_C) &&
                   (r_h_cnt <  H_END_C);
  assign w_v_act = (r_v_cnt >= V_BEG_C) &&
                   (r_v_cnt <  V_END_C);
  assign w_active = w_h_act && w_v_act;

  assign w_h_off = r_h_cnt - H_BEG_C;
  assign w_v_off = r_v_cnt - V_BEG_C;

  always_comb begin
    h_addr = '0;
    v_addr = '0;
    if (w_active) begin
      h_addr = 10'(w_h_off);
      v_addr = 9'(w_v_off);
    end
  end

  // Outputs register the counters seen at pix_en, so they
  // trail the address by one pixel, matching the frame
  // buffer's data for that address.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_div   <= '0;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_valid <= 1'b0;
      r_rgb   <= '0;
      r_fs    <= 1'b0;
    end else if (!Enable) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_valid <= 1'b0;
      r_rgb   <= '0;
      r_fs    <= 1'b0;
    end else begin
      r_fs <= 1'b0;
      if (w_pix_en) begin
        r_div <= '0;
        r_h_cnt <= w_h_wrap ? '0
                            : r_h_cnt + HW'(1);
        if (w_h_wrap) begin
          r_v_cnt <= w_v_wrap ? '0
                              : r_v_cnt + VW'(1);
        end
        r_hsync <= !(r_h_cnt < H_SYN_C);
        r_vsync <= !(r_v_cnt < V_SYN_C);
        r_valid <= w_active;
        r_rgb   <= w_active ? vga_data : '0;
        r_fs    <= w_h_wrap && w_v_wrap;
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign valid       = r_valid;
  assign frame_start = r_fs;
  assign vga_r       = r_rgb[23:16];
  assign vga_g       = r_rgb[15:8];
  assign vga_b       = r_rgb[7:0];

endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: scoreboard bench for vga_ctrl.
// Full horizontal timing, shortened vertical timing.
`timescale 1ns/1ps

module tb_vga_ctrl;

  localparam int HS  = 96;
  localparam int HB  = 48;
  localparam int HA  = 640;
  localparam int HT  = 800;
  localparam int VS  = 2;
  localparam int VB  = 2;
  localparam int VA  = 3;
  localparam int VF  = 1;
  localparam int VT  = 8;
  localparam int DIV = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rst1_n;
  logic        en;

  logic [23:0] data0;
  logic [9:0]  ha0;
  logic [8:0]  va0;
  logic        hsync0, vsync0, valid0, fs0;
  logic [7:0]  r0, g0, b0;

  logic [23:0] data1;
  logic [9:0]  ha1;
  logic [8:0]  va1;
  logic        hsync1, vsync1, valid1, fs1;
  logic [7:0]  r1, g1, b1;

  assign data0 = {ha0[7:0], va0[7:0], 8'hA5};
  assign data1 = {ha1[7:0], va1[7:0], 8'hA5};

  vga_ctrl #(
    .CLK_DIV(DIV), .V_SYNC(VS), .V_BACK(VB),
    .V_ACTIVE(VA), .V_FRONT(VF)
  ) u_dut (
    .Clk(clk), .Rst(rst_n), .Enable(en),
    .vga_data(data0), .h_addr(ha0),
    .v_addr(va0), .hsync(hsync0),
    .vsync(vsync0), .valid(valid0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0),
    .frame_start(fs0)
  );

  vga_ctrl #(
    .CLK_DIV(1), .V_SYNC(VS), .V_BACK(VB),
    .V_ACTIVE(VA), .V_FRONT(VF)
  ) u_dut1 (
    .Clk(clk), .Rst(rst1_n), .Enable(1'b1),
    .vga_data(data1), .h_addr(ha1),
    .v_addr(va1), .hsync(hsync1),
    .vsync(vsync1), .valid(valid1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .frame_start(fs1)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        vl;
    logic        fs;
    logic [23:0] rgb;
    logic [9:0]  ha;
    logic [8:0]  va;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] req);
    checks++;
    if (got !== req) begin
      fails++;
      if (fails <= 20)
        $display("FAIL %s t=%0t got=%h req=%h",
                 nm, $time, got, req);
    end
  endtask

  function automatic bit in_act(int h, int v);
    return (h >= HS + HB) && (h < HS + HB + HA) &&
           (v >= VS + VB) && (v < VS + VB + VA);
  endfunction

  // Reference model: linear pixel index within the frame,
  // expected response pushed at every rising edge.
  int   m_div = 0;
  int   m_p   = 0;
  exp_t m;

  always @(posedge clk) begin
    int h;
    int v;
    bit act;
    if (!rst_n) begin
      m_div = 0;
      m_p   = 0;
      m.hs  = 1'b1;
      m.vs  = 1'b1;
      m.vl  = 1'b0;
      m.fs  = 1'b0;
      m.rgb = '0;
    end else if (!en) begin
      m.hs  = 1'b1;
      m.vs  = 1'b1;
      m.vl  = 1'b0;
      m.fs  = 1'b0;
      m.rgb = '0;
    end else begin
      m.fs = 1'b0;
      if (m_div == DIV - 1) begin
        h     = m_p % HT;
        v     = m_p / HT;
        act   = in_act(h, v);
        m.hs  = (h >= HS);
        m.vs  = (v >= VS);
        m.vl  = act;
        m.rgb = act ? {8'(h - HS - HB),
                       8'(v - VS - VB), 8'hA5}
                    : 24'h0;
        m.fs  = (m_p == HT * VT - 1);
        m_p   = (m_p + 1) % (HT * VT);
        m_div = 0;
      end else begin
        m_div++;
      end
    end
    h    = m_p % HT;
    v    = m_p / HT;
    m.ha = in_act(h, v) ? 10'(h - HS - HB) : 10'd0;
    m.va = in_act(h, v) ? 9'(v - VS - VB) : 9'd0;
    q.push_back(m);
  end

  // Monitor: compares the DUT every cycle it has an
  // expected response queued.
  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (q.size() > 0) begin
      e     = q.pop_front();
      g.hs  = hsync0;
      g.vs  = vsync0;
      g.vl  = valid0;
      g.fs  = fs0;
      g.rgb = {r0, g0, b0};
      g.ha  = ha0;
      g.va  = va0;
      chk("sb", 64'(g), 64'(e));
    end
  end

  initial begin
    int   fall1, rise1, fall2, n, cyc;
    int   vlow, vhigh;
    logic prev;
    rst_n  = 1'b0;
    rst1_n = 1'b0;
    en     = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_out",
        {hsync0, vsync0, valid0, fs0, r0, g0, b0},
        28'hC00_0000);
    chk("reset_addr", {ha0, va0}, 19'h0);
    rst_n = 1'b1;

    fall1 = -1;
    rise1 = -1;
    fall2 = -1;
    prev  = 1'b1;
    for (int i = 1; i <= 1700; i++) begin
      @(negedge clk);
      if (prev && !hsync0) begin
        if (fall1 < 0) fall1 = i;
        else if (fall2 < 0) fall2 = i;
      end
      if (!prev && hsync0 && rise1 < 0) rise1 = i;
      prev = hsync0;
    end
    chk("hs_first_fall", 64'(fall1), 64'(2));
    chk("hs_first_rise", 64'(rise1), 64'(194));
    chk("hs_period", 64'(fall2 - fall1), 64'(1600));

    n = 0;
    while (!fs0 && n < 14000) begin
      @(negedge clk);
      n++;
    end
    chk("fs_first", 64'(1700 + n), 64'(12800));

    cyc   = 0;
    vlow  = 0;
    vhigh = 0;
    do begin
      if (!vsync0) vlow++;
      if (valid0) vhigh++;
      cyc++;
      @(negedge clk);
    end while (!fs0 && cyc < 14000);
    chk("fs_period", 64'(cyc), 64'(12800));
    chk("vsync_low", 64'(vlow), 64'(3200));
    chk("valid_clks", 64'(vhigh), 64'(3840));

    n = 0;
    while (!(ha0 == 10'd156 && va0 == 9'd1) &&
           n < 14000) begin
      @(negedge clk);
      n++;
    end
    chk("gap_reach", {ha0, va0}, {10'd156, 9'd1});
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("gap_blank", {hsync0, vsync0, valid0, ha0},
          {3'b110, 10'd156});
    end
    en = 1'b1;
    n = 0;
    while (ha0 == 10'd156 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("gap_resume", 64'(ha0), 64'(157));
    chk("gap_resume_lat", 64'(n), 64'(2));

    rst1_n = 1'b1;
    n = 0;
    while (!(ha1 == 10'd100 && va1 == 9'd1) &&
           n < 7000) begin
      @(negedge clk);
      n++;
    end
    chk("d1_pre_valid", {valid1, r1},
        {1'b1, 8'd99});
    @(posedge clk);
    #3 rst1_n = 1'b0;
    #1;
    chk("d1_async_rst",
        {hsync1, vsync1, valid1, fs1, r1, g1, b1},
        28'hC00_0000);
    chk("d1_async_addr", {ha1, va1}, 19'h0);
    @(negedge clk);
    rst1_n = 1'b1;
    fall1 = -1;
    rise1 = -1;
    prev  = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (prev && !hsync1 && fall1 < 0) fall1 = i;
      if (!prev && hsync1 && rise1 < 0) rise1 = i;
      prev = hsync1;
    end
    chk("d1_hs_fall", 64'(fall1), 64'(1));
    chk("d1_hs_width", 64'(rise1 - fall1), 64'(96));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
